// File: rtl/crtc_sched_pkg.sv
// rtl/crtc_sched_pkg.sv - slot phases, access tags and video address helper for the CRTC VRAM scheduler
package crtc_sched_pkg;

    localparam logic [3:0] PH_LATCH = 4'd0;
    localparam logic [3:0] PH_V0    = 4'd2;
    localparam logic [3:0] PH_V1    = 4'd6;
    localparam logic [3:0] PH_CPU   = 4'd10;
    localparam logic [3:0] PH_CLKEN = 4'd15;

    typedef enum logic [2:0] {
        NONE,
        VID0,
        VID1,
        CPU_RD,
        CPU_WR
    } acc_e;

    function automatic logic [15:0] vid_addr(input logic [1:0] ma_hi, input logic [2:0] ra_lo,
                                             input logic [9:0] ma_lo, input logic b);
        return {ma_hi, ra_lo, ma_lo, b};
    endfunction

endpackage

// File: rtl/crtc_vram_sched_if.sv
// rtl/crtc_vram_sched_if.sv - CPU request/acknowledge bus into the VRAM scheduler
interface crtc_vram_sched_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        cpu_wait;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack, cpu_wait
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack, cpu_wait
    );

endinterface

// File: rtl/sched_rdpipe.sv
// rtl/sched_rdpipe.sv - delays the access tag by the RAM read latency so returning data can be steered
module sched_rdpipe
    import crtc_sched_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic CLOCK,
    input  logic nRESET,
    input  acc_e tag_i,
    output acc_e tag_o
);

    acc_e pipe_q [RD_LATENCY];

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= NONE;
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tag_o = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/crtc_vram_sched.sv
// rtl/crtc_vram_sched.sv - 16-phase time-sliced VRAM scheduler: two video byte fetches and one CPU slot per CRTC clock
module crtc_vram_sched
    import crtc_sched_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic                    CLOCK,
    input  logic                    nRESET,
    output logic                    crtc_clken,
    input  logic [13:0]             crtc_ma,
    input  logic [4:0]              crtc_ra,
    input  logic                    crtc_de,
    crtc_vram_sched_if.slave        cpu,
    output logic [15:0]             mem_addr,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [7:0]              mem_dout,
    input  logic [7:0]              mem_din,
    output logic [15:0]             vid_data,
    output logic                    vid_de,
    output logic                    vid_valid
);

    logic [3:0]  phase_q, phase_d;
    logic        clken_q;
    logic [13:0] ma_q;
    logic [4:0]  ra_q;
    logic        de_q;
    acc_e        acc_q, acc_d;
    acc_e        rd_tag;
    logic [15:0] mem_addr_q, addr_d;
    logic [7:0]  mem_dout_q, dout_d;
    logic [7:0]  byte0_q;
    logic [15:0] vid_data_q;
    logic        vid_de_q;
    logic        vid_valid_q;
    logic [7:0]  cpu_dout_q;
    logic        unused_bits;

    assign unused_bits = ^{ma_q[11:10], ra_q[4:3]};

    // Strobes are decided on the edge that enters their phase, so they are registered.
    always_comb begin
        phase_d = phase_q + 4'd1;
        acc_d   = NONE;
        case (phase_d)
            PH_V0:   acc_d = VID0;
            PH_V1:   acc_d = VID1;
            PH_CPU:  if (cpu.cpu_req) acc_d = cpu.cpu_we ? CPU_WR : CPU_RD;
            default: acc_d = NONE;
        endcase

        addr_d = mem_addr_q;
        dout_d = mem_dout_q;
        case (acc_d)
            VID0:    addr_d = vid_addr(ma_q[13:12], ra_q[2:0], ma_q[9:0], 1'b0);
            VID1:    addr_d = vid_addr(ma_q[13:12], ra_q[2:0], ma_q[9:0], 1'b1);
            CPU_RD:  addr_d = cpu.cpu_addr;
            CPU_WR: begin
                addr_d = cpu.cpu_addr;
                dout_d = cpu.cpu_din;
            end
            default: addr_d = mem_addr_q;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            phase_q     <= '0;
            clken_q     <= 1'b0;
            ma_q        <= '0;
            ra_q        <= '0;
            de_q        <= 1'b0;
            acc_q       <= NONE;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            byte0_q     <= '0;
            vid_data_q  <= '0;
            vid_de_q    <= 1'b0;
            vid_valid_q <= 1'b0;
            cpu_dout_q  <= '0;
        end else begin
            phase_q    <= phase_d;
            clken_q    <= (phase_d == PH_CLKEN);
            if (phase_q == PH_LATCH) begin
                ma_q <= crtc_ma;
                ra_q <= crtc_ra;
                de_q <= crtc_de;
            end
            acc_q      <= acc_d;
            mem_addr_q <= addr_d;
            mem_dout_q <= dout_d;
            if (rd_tag == VID0) byte0_q <= mem_din;
            vid_valid_q <= (rd_tag == VID1);
            if (rd_tag == VID1) begin
                vid_data_q <= {mem_din, byte0_q};
                vid_de_q   <= de_q;
            end
            if (rd_tag == CPU_RD) cpu_dout_q <= mem_din;
        end
    end

    sched_rdpipe #(.RD_LATENCY(RD_LATENCY)) u_rdpipe (
        .CLOCK  (CLOCK),
        .nRESET (nRESET),
        .tag_i  (acc_q),
        .tag_o  (rd_tag)
    );

    assign crtc_clken = clken_q;
    assign mem_addr   = mem_addr_q;
    assign mem_dout   = mem_dout_q;
    assign mem_rd     = (acc_q == VID0) || (acc_q == VID1) || (acc_q == CPU_RD);
    assign mem_wr     = (acc_q == CPU_WR);
    assign vid_data   = vid_data_q;
    assign vid_de     = vid_de_q;
    assign vid_valid  = vid_valid_q;

    // Read data is forwarded in the ack cycle itself, then held until the next read ack.
    assign cpu.cpu_ack  = (rd_tag == CPU_RD) || (rd_tag == CPU_WR);
    assign cpu.cpu_dout = (rd_tag == CPU_RD) ? mem_din : cpu_dout_q;
    assign cpu.cpu_wait = cpu.cpu_req & ~cpu.cpu_ack;

endmodule

// File: tb/tb_crtc_vram_sched.sv
// tb/tb_crtc_vram_sched.sv - directed self-checking bench for crtc_vram_sched at read latencies 2 and 3
module tb_crtc_vram_sched;

    logic        CLOCK = 1'b0;
    logic        nRESET = 1'b0;
    logic [13:0] crtc_ma;
    logic [4:0]  crtc_ra;
    logic        crtc_de;

    logic        clken2, clken3, rd2, rd3, wr2, wr3, vde2, vde3, vval2, vval3;
    logic [15:0] addr2, addr3, vdata2, vdata3;
    logic [7:0]  dout2, dout3, din2, din3;

    logic [7:0]  ram2 [0:65535];
    logic [7:0]  ram3 [0:65535];
    logic [7:0]  pipe2 [0:1];
    logic [7:0]  pipe3 [0:2];
    logic [3:0]  tb_phase = 4'd0;

    int n_checks = 0;
    int n_fail   = 0;

    crtc_vram_sched_if cpu2 ();
    crtc_vram_sched_if cpu3 ();

    crtc_vram_sched #(.RD_LATENCY(2)) dut2 (
        .CLOCK(CLOCK), .nRESET(nRESET), .crtc_clken(clken2),
        .crtc_ma(crtc_ma), .crtc_ra(crtc_ra), .crtc_de(crtc_de), .cpu(cpu2),
        .mem_addr(addr2), .mem_rd(rd2), .mem_wr(wr2), .mem_dout(dout2), .mem_din(din2),
        .vid_data(vdata2), .vid_de(vde2), .vid_valid(vval2)
    );

    crtc_vram_sched #(.RD_LATENCY(3)) dut3 (
        .CLOCK(CLOCK), .nRESET(nRESET), .crtc_clken(clken3),
        .crtc_ma(crtc_ma), .crtc_ra(crtc_ra), .crtc_de(crtc_de), .cpu(cpu3),
        .mem_addr(addr3), .mem_rd(rd3), .mem_wr(wr3), .mem_dout(dout3), .mem_din(din3),
        .vid_data(vdata3), .vid_de(vde3), .vid_valid(vval3)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) tb_phase <= nRESET ? tb_phase + 4'd1 : 4'd0;

    // RAM models: data for a strobe seen in phase s is driven only during phase s+L.
    always @(negedge CLOCK) begin
        din2     = pipe2[1];
        pipe2[1] = pipe2[0];
        pipe2[0] = rd2 ? ram2[addr2] : 8'hEE;
        if (wr2) ram2[addr2] = dout2;
        din3     = pipe3[2];
        pipe3[2] = pipe3[1];
        pipe3[1] = pipe3[0];
        pipe3[0] = rd3 ? ram3[addr3] : 8'hEE;
        if (wr3) ram3[addr3] = dout3;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge CLOCK);
        #1;
    endtask

    task automatic wait_phase(input logic [3:0] p);
        for (int i = 0; i < 16 && tb_phase != p; i++) step();
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({clken2, rd2, wr2, cpu2.cpu_ack, vval2} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 00000", {clken2, rd2, wr2, cpu2.cpu_ack, vval2});
        end
        n_checks++;
        if (vdata2 !== 16'h0 || vde2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_video: got %h/%b want 0000/0", vdata2, vde2);
        end
        n_checks++;
        if (addr2 !== 16'h0 || dout2 !== 8'h0 || cpu2.cpu_dout !== 8'h0) begin
            n_fail++; $display("FAIL reset_bus: got addr %h dout %h cpu_dout %h want 0", addr2, dout2, cpu2.cpu_dout);
        end
        n_checks++;
        if ({clken3, rd3, wr3, cpu3.cpu_ack, vval3} !== 5'b0 || addr3 !== 16'h0) begin
            n_fail++; $display("FAIL reset_lat3: got %b addr %h want 0", {clken3, rd3, wr3, cpu3.cpu_ack, vval3}, addr3);
        end
        nRESET = 1'b1;
    endtask

    task automatic test_clken();
        for (int c = 0; c < 32; c++) begin
            n_checks++;
            if (clken2 !== (c == 15 || c == 31) || clken3 !== (c == 15 || c == 31)) begin
                n_fail++; $display("FAIL clken cycle %0d: got %b/%b want %b", c, clken2, clken3, (c == 15 || c == 31));
            end
            n_checks++;
            if (wr2 !== 1'b0 || rd2 !== (c % 16 == 2 || c % 16 == 6)) begin
                n_fail++; $display("FAIL idle_strobes cycle %0d: got rd %b wr %b", c, rd2, wr2);
            end
            step();
        end
    endtask

    task automatic test_video();
        logic [15:0] a0, a1, vd;
        logic        de;
        for (int v = 0; v < 2; v++) begin
            crtc_ma = (v == 0) ? 14'h3001 : 14'h0005;
            crtc_ra = (v == 0) ? 5'd2 : 5'd7;
            crtc_de = (v == 0);
            a0 = (v == 0) ? 16'hD002 : 16'h380A;
            a1 = (v == 0) ? 16'hD003 : 16'h380B;
            vd = (v == 0) ? 16'h0302 : 16'h0B0A;
            de = (v == 0);
            step();
            wait_phase(4'd1);
            for (int k = 1; k < 16; k++) begin
                if (k == 2 || k == 6) begin
                    n_checks++;
                    if (rd2 !== 1'b1 || addr2 !== ((k == 2) ? a0 : a1)) begin
                        n_fail++; $display("FAIL vid_fetch ph %0d: got rd %b addr %h want 1 %h", k, rd2, addr2, (k == 2) ? a0 : a1);
                    end
                end
                if (k == 7) begin
                    n_checks++;
                    if (addr2 !== a1) begin
                        n_fail++; $display("FAIL addr_hold: got %h want %h", addr2, a1);
                    end
                end
                n_checks++;
                if (vval2 !== (k == 9) || vval3 !== (k == 10)) begin
                    n_fail++; $display("FAIL vid_valid ph %0d: got %b/%b want %b/%b", k, vval2, vval3, (k == 9), (k == 10));
                end
                if (k == 9) begin
                    n_checks++;
                    if (vdata2 !== vd || vde2 !== de) begin
                        n_fail++; $display("FAIL vid_data: got %h/%b want %h/%b", vdata2, vde2, vd, de);
                    end
                end
                if (k == 10) begin
                    n_checks++;
                    if (vdata3 !== vd || vde3 !== de) begin
                        n_fail++; $display("FAIL vid_data_lat3: got %h/%b want %h/%b", vdata3, vde3, vd, de);
                    end
                end
                step();
            end
        end
    endtask

    task automatic test_cpu_read();
        wait_phase(4'd3);
        cpu2.cpu_req = 1'b1; cpu2.cpu_we = 1'b0; cpu2.cpu_addr = 16'h4000; cpu2.cpu_din = 8'h00;
        #1;
        for (int k = 3; k < 14; k++) begin
            n_checks++;
            if (cpu2.cpu_wait !== (k <= 11) || cpu2.cpu_ack !== (k == 12)) begin
                n_fail++; $display("FAIL rd_handshake ph %0d: got wait %b ack %b want %b %b", k, cpu2.cpu_wait, cpu2.cpu_ack, (k <= 11), (k == 12));
            end
            if (k == 10) begin
                n_checks++;
                if (rd2 !== 1'b1 || wr2 !== 1'b0 || addr2 !== 16'h4000) begin
                    n_fail++; $display("FAIL rd_strobe: got rd %b wr %b addr %h want 1 0 4000", rd2, wr2, addr2);
                end
            end
            if (k >= 12) begin
                n_checks++;
                if (cpu2.cpu_dout !== 8'h3C) begin
                    n_fail++; $display("FAIL rd_data ph %0d: got %h want 3c", k, cpu2.cpu_dout);
                end
            end
            if (k == 12) cpu2.cpu_req = 1'b0;
            step();
        end
    endtask

    task automatic test_cpu_write();
        wait_phase(4'd11);
        cpu2.cpu_req = 1'b1; cpu2.cpu_we = 1'b1; cpu2.cpu_addr = 16'h1234; cpu2.cpu_din = 8'hA5;
        #1;
        for (int i = 0; i < 18; i++) begin
            n_checks++;
            if (wr2 !== (i == 15) || cpu2.cpu_ack !== (i == 17) || cpu2.cpu_wait !== (i < 17)) begin
                n_fail++; $display("FAIL wr_timing step %0d: got wr %b ack %b wait %b", i, wr2, cpu2.cpu_ack, cpu2.cpu_wait);
            end
            if (i == 15) begin
                n_checks++;
                if (addr2 !== 16'h1234 || dout2 !== 8'hA5 || rd2 !== 1'b0) begin
                    n_fail++; $display("FAIL wr_bus: got addr %h dout %h rd %b want 1234 a5 0", addr2, dout2, rd2);
                end
            end
            if (i == 17) begin
                n_checks++;
                if (cpu2.cpu_dout !== 8'h3C) begin
                    n_fail++; $display("FAIL wr_keeps_dout: got %h want 3c", cpu2.cpu_dout);
                end
                cpu2.cpu_req = 1'b0;
            end
            step();
        end
        wait_phase(4'd5);
        cpu2.cpu_req = 1'b1; cpu2.cpu_we = 1'b0;
        for (int k = 5; k < 14; k++) begin
            if (k >= 12) begin
                n_checks++;
                if (cpu2.cpu_dout !== 8'hA5 || cpu2.cpu_ack !== (k == 12)) begin
                    n_fail++; $display("FAIL readback ph %0d: got %h ack %b want a5 %b", k, cpu2.cpu_dout, cpu2.cpu_ack, (k == 12));
                end
            end
            if (k == 12) cpu2.cpu_req = 1'b0;
            step();
        end
    endtask

    task automatic test_req_drop();
        wait_phase(4'd4);
        cpu2.cpu_req = 1'b1; cpu2.cpu_we = 1'b0; cpu2.cpu_addr = 16'h0100;
        wait_phase(4'd7);
        cpu2.cpu_req = 1'b0;
        for (int k = 7; k < 16; k++) begin
            n_checks++;
            if (cpu2.cpu_ack !== 1'b0 || (k == 10 && (rd2 !== 1'b0 || wr2 !== 1'b0))) begin
                n_fail++; $display("FAIL req_drop ph %0d: got ack %b rd %b wr %b want 0", k, cpu2.cpu_ack, rd2, wr2);
            end
            step();
        end
    endtask

    task automatic test_reset_inflight();
        wait_phase(4'd3);
        cpu2.cpu_req = 1'b1; cpu2.cpu_we = 1'b0; cpu2.cpu_addr = 16'h4000;
        wait_phase(4'd11);
        nRESET = 1'b0;
        cpu2.cpu_req = 1'b0;
        step();
        n_checks++;
        if (cpu2.cpu_ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_ack: got %b want 0", cpu2.cpu_ack);
        end
        nRESET = 1'b1;
        for (int c = 0; c < 16; c++) begin
            n_checks++;
            if (cpu2.cpu_ack !== 1'b0 || clken2 !== (c == 15) || rd2 !== (c == 2 || c == 6)) begin
                n_fail++; $display("FAIL post_reset cycle %0d: got ack %b clken %b rd %b", c, cpu2.cpu_ack, clken2, rd2);
            end
            n_checks++;
            if (vval2 !== (c == 9) || vval3 !== (c == 10)) begin
                n_fail++; $display("FAIL post_reset_vid cycle %0d: got %b/%b want %b/%b", c, vval2, vval3, (c == 9), (c == 10));
            end
            step();
        end
    endtask

    task automatic test_latency3();
        crtc_ma = 14'h3001; crtc_ra = 5'd2; crtc_de = 1'b1;
        step();
        wait_phase(4'd1);
        for (int k = 1; k < 16; k++) begin
            if (k == 3) begin
                cpu3.cpu_req = 1'b1; cpu3.cpu_we = 1'b0; cpu3.cpu_addr = 16'h4000; cpu3.cpu_din = 8'h00;
                #1;
            end
            n_checks++;
            if (vval3 !== (k == 10) || cpu3.cpu_ack !== (k == 13)) begin
                n_fail++; $display("FAIL lat3_timing ph %0d: got valid %b ack %b want %b %b", k, vval3, cpu3.cpu_ack, (k == 10), (k == 13));
            end
            if (k == 10) begin
                n_checks++;
                if (vdata3 !== 16'h0302 || rd3 !== 1'b1 || addr3 !== 16'h4000) begin
                    n_fail++; $display("FAIL lat3_ph10: got vid %h rd %b addr %h want 0302 1 4000", vdata3, rd3, addr3);
                end
            end
            if (k >= 13) begin
                n_checks++;
                if (cpu3.cpu_dout !== 8'h5A) begin
                    n_fail++; $display("FAIL lat3_dout ph %0d: got %h want 5a", k, cpu3.cpu_dout);
                end
            end
            if (k == 13) cpu3.cpu_req = 1'b0;
            step();
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        wait_phase(4'd0);
        cpu2.cpu_req = 1'b1; cpu2.cpu_we = 1'b0; cpu2.cpu_addr = 16'h0077;
        for (int c = 0; c < 32; c++) begin
            if (cpu2.cpu_ack === 1'b1) acks++;
            n_checks++;
            if ((rd2 || wr2) && !(c % 16 == 2 || c % 16 == 6 || c % 16 == 10)) begin
                n_fail++; $display("FAIL slot_strobe cycle %0d: got rd %b wr %b outside slots", c, rd2, wr2);
            end
            step();
        end
        cpu2.cpu_req = 1'b0;
        n_checks++;
        if (acks != 2 || cpu2.cpu_dout !== 8'h77) begin
            n_fail++; $display("FAIL one_per_period: got %0d acks dout %h want 2 77", acks, cpu2.cpu_dout);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            ram2[a] = a[7:0];
            ram3[a] = a[7:0];
        end
        ram2[16'h4000] = 8'h3C;
        ram3[16'h4000] = 8'h5A;
        pipe2[0] = 8'hEE; pipe2[1] = 8'hEE;
        pipe3[0] = 8'hEE; pipe3[1] = 8'hEE; pipe3[2] = 8'hEE;
        crtc_ma = 14'h0; crtc_ra = 5'h0; crtc_de = 1'b0;
        cpu2.cpu_req = 1'b0; cpu2.cpu_we = 1'b0; cpu2.cpu_addr = 16'h0; cpu2.cpu_din = 8'h0;
        cpu3.cpu_req = 1'b0; cpu3.cpu_we = 1'b0; cpu3.cpu_addr = 16'h0; cpu3.cpu_din = 8'h0;

        test_reset();
        test_clken();
        test_video();
        test_cpu_read();
        test_cpu_write();
        test_req_drop();
        test_reset_inflight();
        test_latency3();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
